// File: rtl/vector_addsub_sequencer.sv
// Vector add/sub sequencer: streams operand pairs into a pipelined FP32
// adder, tracks its latency and writes results back to a destination memory.
module vector_addsub_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_in,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic [31:0]       adder_a,
    output logic [31:0]       adder_b,
    output logic              adder_op,
    output logic              adder_ce,
    output logic              adder_start,
    output logic              outsider15,
    input  logic [31:0]       adder_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t              state;
    state_t              state_nx;
    logic                op_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     rd_cnt;
    logic [ADDR_W:0]     wr_cnt;
    logic [ADDR_W:0]     wr_cnt_nx;
    logic                issue_v;
    logic [LATENCY-1:0]  vpipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            op_q    <= 1'b0;
            len_q   <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            issue_v <= 1'b0;
            vpipe   <= '0;
        end else begin
            state   <= state_nx;
            issue_v <= rd_en;
            vpipe[0] <= issue_v;
            for (int i = 1; i < LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            wr_cnt <= wr_cnt_nx;
            if (rd_en) begin
                rd_cnt <= rd_cnt + ONE;
            end
            if (state == IDLE && start) begin
                op_q   <= op_in;
                len_q  <= len;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
        end
    end

    // Leave DRAIN on the cycle the final write happens so done lands right after it
    assign wr_cnt_nx = wr_en ? wr_cnt + ONE : wr_cnt;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (rd_cnt == len_q - ONE) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_cnt_nx == len_q) begin
                    state_nx = FINISH;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign adder_ce    = busy;
    assign adder_start = busy;
    assign adder_op    = op_q;

    assign rd_en   = (state == ISSUE);
    assign rd_addr = rd_cnt[ADDR_W-1:0];

    // Operands are forced to zero outside their valid slot so reset shows all-zero outputs
    assign adder_a = issue_v ? rd_data_a : 32'h0;
    assign adder_b = issue_v ? rd_data_b : 32'h0;

    assign outsider15 = vpipe[LATENCY-1];
    assign wr_en      = outsider15;
    assign wr_addr    = wr_cnt[ADDR_W-1:0];
    assign wr_data    = outsider15 ? adder_result : 32'h0;

endmodule
